// File: rtl/jtkicker_colmix.sv
// Final colour mixer: merges object and tilemap pixels, looks the result up in
// a 32x8 RGB PROM and drives gated 4-bit RGB with matching delayed blanking.
// Optional build macro JTKICKER_LAYER_MASK_EN adds gfx_en[1:0] layer enables
// (bit 0 = tilemap, bit 1 = objects).
module jtkicker_colmix #(
  parameter int unsigned PIPE_DLY = 3,
  parameter string       SIMFILE  = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [3:0] obj_pxl,
  input  logic [3:0] scr_pxl,
  input  logic       scr_prio,
  input  logic [4:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       prog_en,
`ifdef JTKICKER_LAYER_MASK_EN
  input  logic [1:0] gfx_en,
`endif
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  // PROM contents always arrive through the prog_* download port; SIMFILE is
  // only a hook for simulation harnesses that preload the array externally.
  if (SIMFILE != "") begin : g_simfile_hook
  end

  logic [7:0] prom [32];

  logic [3:0] obj_eff, scr_eff;
  logic       sel_obj;
  logic [4:0] col_mux;

  logic [4:0] col_idx;
  logic [7:0] rgb8;
  logic [PIPE_DLY-1:0] lhbl_sr, lvbl_sr;

  logic [3:0] red_q, green_q, blue_q;
  logic [3:0] red_d, green_d, blue_d;
  logic       visible;

  // Layer masking ahead of the priority mux
  always_comb begin
`ifdef JTKICKER_LAYER_MASK_EN
    obj_eff = gfx_en[1] ? obj_pxl : 4'd0;
    scr_eff = gfx_en[0] ? scr_pxl : 4'd0;
`else
    obj_eff = obj_pxl;
    scr_eff = scr_pxl;
`endif
  end

  // Priority: an opaque tile with prio set hides the object
  always_comb begin
    sel_obj = (obj_eff != 4'd0) && !(scr_prio && (scr_eff != 4'd0));
    col_mux = sel_obj ? {1'b1, obj_eff} : {1'b0, scr_eff};
  end

  // PROM download port; writes ignore pxl_cen and are never reset
  always_ff @(posedge clk) begin
    if (prog_en) prom[prog_addr] <= prog_data;
  end

  // Stages 1 and 2 plus the blanking delay line, all gated by pxl_cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= 5'd0;
      rgb8    <= 8'd0;
      lhbl_sr <= '0;
      lvbl_sr <= '0;
    end else if (pxl_cen) begin
      col_idx <= col_mux;
      rgb8    <= prom[col_idx];
      lhbl_sr <= {lhbl_sr[PIPE_DLY-2:0], LHBL};
      lvbl_sr <= {lvbl_sr[PIPE_DLY-2:0], LVBL};
    end
  end

  // Stage 3 colour expansion, blanked with the blank bits travelling alongside
  always_comb begin
    visible = lhbl_sr[PIPE_DLY-2] & lvbl_sr[PIPE_DLY-2];
    red_d   = visible ? {rgb8[2:0], rgb8[2]}   : 4'd0;
    green_d = visible ? {rgb8[5:3], rgb8[5]}   : 4'd0;
    blue_d  = visible ? {rgb8[7:6], rgb8[7:6]} : 4'd0;
  end

  // Output register; a download clears it so stale colours do not reappear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
    end else if (prog_en) begin
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
    end else if (pxl_cen) begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  // Outputs: prog_en gates immediately, the register holds 0 until next pxl_cen
  always_comb begin
    red      = prog_en ? 4'd0 : red_q;
    green    = prog_en ? 4'd0 : green_q;
    blue     = prog_en ? 4'd0 : blue_q;
    LHBL_dly = lhbl_sr[PIPE_DLY-1];
    LVBL_dly = lvbl_sr[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_jtkicker_colmix.sv
// Randomised self-checking bench for jtkicker_colmix against a pixel-level
// reference model (PROM mirror plus a history of presented pixels).
module tb_jtkicker_colmix;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b0, LVBL = 1'b0;
  logic [3:0] obj_pxl = 4'd0, scr_pxl = 4'd0;
  logic       scr_prio = 1'b0;
  logic [4:0] prog_addr = 5'd0;
  logic [7:0] prog_data = 8'd0;
  logic       prog_en = 1'b0;
  logic [1:0] gfx_en = 2'b11;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtkicker_colmix dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .obj_pxl   (obj_pxl),
    .scr_pxl   (scr_pxl),
    .scr_prio  (scr_prio),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_en   (prog_en),
`ifdef JTKICKER_LAYER_MASK_EN
    .gfx_en    (gfx_en),
`endif
    .red       (red),
    .green     (green),
    .blue      (blue),
    .LHBL_dly  (LHBL_dly),
    .LVBL_dly  (LVBL_dly)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    bit          lh;
    bit          lv;
  } pix_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned prom_m [32];
  pix_t        hist [$];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 3-bit channels scale x2 plus MSB; 2-bit blue repeats itself (x5)
  function automatic int unsigned expand(input int unsigned v);
    int unsigned r3, g3, b2;
    r3 = v % 8;
    g3 = (v / 8) % 8;
    b2 = v / 64;
    return ((r3 * 2 + r3 / 4) << 8) | ((g3 * 2 + g3 / 4) << 4) | (b2 * 5);
  endfunction

  // Palette index chosen by the layer rules
  function automatic int unsigned pick(input int unsigned o, input int unsigned s,
                                       input bit p, input bit [1:0] m);
    int unsigned oe, se;
    oe = m[1] ? o : 0;
    se = m[0] ? s : 0;
    if (p && se != 0) return se;
    if (oe != 0) return 16 + oe;
    return se;
  endfunction

  function automatic bit [1:0] eff_mask();
`ifdef JTKICKER_LAYER_MASK_EN
    return gfx_en;
`else
    return 2'b11;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    int unsigned exp_rgb, exp_blk;
    pix_t e;
    exp_rgb = 0;
    exp_blk = 0;
    if (hist.size() >= 3) begin
      e = hist[hist.size() - 3];
      exp_blk = {30'd0, e.lh, e.lv};
      if (e.lh && e.lv) exp_rgb = expand(prom_m[e.idx]);
    end
    check({tag, "_rgb"}, {20'd0, red, green, blue}, exp_rgb);
    check({tag, "_blank"}, {30'd0, LHBL_dly, LVBL_dly}, exp_blk);
  endtask

  // One pixel: idle a few clocks, present inputs for a single pxl_cen, check
  task automatic pix_tick(input int unsigned o, input int unsigned s, input bit p,
                          input bit lh, input bit lv, input string tag);
    pix_t e;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    obj_pxl  = o[3:0];
    scr_pxl  = s[3:0];
    scr_prio = p;
    LHBL     = lh;
    LVBL     = lv;
    pxl_cen  = 1'b1;
    @(negedge clk);
    pxl_cen  = 1'b0;
    e.idx = pick(o, s, p, eff_mask());
    e.lh  = lh;
    e.lv  = lv;
    hist.push_back(e);
    check_outputs(tag);
  endtask

  // Download one or more clocks of the same byte; two blanked pixels first so
  // no in-flight read straddles the write
  task automatic prom_load(input int unsigned a, input int unsigned d, input int unsigned clks);
    pix_tick(0, 0, 0, 0, 1, "preload");
    pix_tick(0, 0, 0, 0, 1, "preload");
    prog_addr = a[4:0];
    prog_data = d[7:0];
    prog_en   = 1'b1;
    for (int i = 0; i < clks; i++) begin
      @(negedge clk);
      check("dl_rgb", {20'd0, red, green, blue}, 0);
    end
    prog_en = 1'b0;
    prom_m[a] = d;
    @(negedge clk);
    check("dl_after_rgb", {20'd0, red, green, blue}, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rgb", {20'd0, red, green, blue}, 0);
    check("rst_blank", {30'd0, LHBL_dly, LVBL_dly}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 32; a++) prom_load(a, $urandom_range(0, 255), 1);

    // PROM load example: 0xA5 at 0x13, object colour 3
    prom_load(5'h13, 8'hA5, 1);
    pix_tick(3, 0, 0, 1, 1, "tp_a");
    pix_tick(3, 0, 0, 1, 1, "tp_b");
    pix_tick(3, 0, 0, 1, 1, "tp_c");
    check("tp_prom_red", {28'd0, red}, 4'hB);
    check("tp_prom_green", {28'd0, green}, 4'h9);
    check("tp_prom_blue", {28'd0, blue}, 4'hA);

    // Priority cases
    pix_tick(2, 7, 0, 1, 1, "prio_obj");
    pix_tick(2, 7, 1, 1, 1, "prio_tile");
    pix_tick(2, 0, 1, 1, 1, "prio_clear_tile");
    repeat (3) pix_tick(0, 0, 0, 1, 1, "prio_flush");

    // Transparency with black and white background
    prom_load(0, 8'h00, 1);
    repeat (3) pix_tick(0, 0, 0, 1, 1, "bg_black");
    check("bg_black_direct", {20'd0, red, green, blue}, 12'h000);
    prom_load(0, 8'hFF, 1);
    repeat (3) pix_tick(0, 0, 0, 1, 1, "bg_white");
    check("bg_white_direct", {20'd0, red, green, blue}, 12'hFFF);

    // Blank alignment: non-zero colour, drop then raise LHBL
    repeat (3) pix_tick(5, 0, 0, 1, 1, "hb_pre");
    pix_tick(5, 0, 0, 0, 1, "hb_fall");
    pix_tick(5, 0, 0, 0, 1, "hb_n1");
    pix_tick(5, 0, 0, 1, 1, "hb_n2");
    check("hb_direct_blank", {31'd0, LHBL_dly}, 0);
    check("hb_direct_rgb", {20'd0, red, green, blue}, 0);
    repeat (3) pix_tick(5, 0, 0, 1, 1, "hb_rise");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
`ifdef JTKICKER_LAYER_MASK_EN
      gfx_en = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
`endif
      pix_tick(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15),
               ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15),
               1'($urandom_range(0, 1)),
               $urandom_range(0, 9) != 0, $urandom_range(0, 19) != 0, "rand");
    end

`ifdef JTKICKER_LAYER_MASK_EN
    gfx_en = 2'b01;
    repeat (3) pix_tick(4, 1, 0, 1, 1, "mask_tile");
    check("mask_tile_direct", {20'd0, red, green, blue}, expand(prom_m[1]));
    gfx_en = 2'b00;
    repeat (3) pix_tick(4, 1, 0, 1, 1, "mask_none");
    check("mask_none_direct", {20'd0, red, green, blue}, expand(prom_m[0]));
    gfx_en = 2'b11;
`endif

    // Reset mid-line with a visible pixel on the output
    prom_load(9, 8'hFF, 1);
    repeat (3) pix_tick(0, 9, 0, 1, 1, "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", {20'd0, red, green, blue}, 0);
    check("midrst_blank", {30'd0, LHBL_dly, LVBL_dly}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    for (int i = 0; i < 4; i++) pix_tick(0, 9, 0, 1, 1, "post_rst");

    // Long download: output stays dark until the next pxl_cen
    prom_load(9, 8'h3C, 10);
    for (int i = 0; i < 4; i++) pix_tick(0, 9, 0, 1, 1, "post_dl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
